// File: rtl/col_pkg.sv
// Shared types and defaults for the column-pipeline frame sequencer.
package col_pkg;

  localparam int unsigned NCOL_DEF = 256;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StRun,
    StDone,
    StErr
  } sched_state_t;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_EARLY_LAST = 2'd1,
    ERR_NO_LAST    = 2'd2,
    ERR_TIMEOUT    = 2'd3
  } err_code_t;

endpackage

// File: rtl/stall_timer.sv
// Watchdog for the RUN phase: counts consecutive stalled cycles and flags the
// cycle on which the count reaches TIMEOUT-1. TIMEOUT must be at least 2.
module stall_timer #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] ExpireAt = CntW'(TIMEOUT - 2);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires on the stalled cycle whose increment would land on TIMEOUT-1.
  assign expire = enable && (cnt_q == ExpireAt);

endmodule

// File: rtl/col_sched.sv
// Frame sequencer for the column pipeline: holds stages in init between frames,
// drives the final-stage request, counts columns and strobes per-column writes.
module col_sched
  import col_pkg::*;
#(
  parameter int unsigned NCOL     = NCOL_DEF,
  parameter int unsigned INIT_CYC = 2,
  parameter int unsigned TIMEOUT  = 4096,
  parameter bit          AUTO_DEF = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    auto_en,
  input  logic                    sink_hold,
  input  logic                    sink_rdy,
  input  logic                    sink_last,
  output logic                    init,
  output logic                    sink_req,
  output logic                    wr_en,
  output logic [$clog2(NCOL)-1:0] wr_addr,
  output logic                    wr_last,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              err_code,
  output logic [15:0]             frame_cnt
);

  localparam int unsigned ColW = $clog2(NCOL);
  localparam int unsigned IcW  = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam logic [ColW-1:0] ColLast  = ColW'(NCOL - 1);
  localparam logic [IcW-1:0]  InitLoad = IcW'(INIT_CYC - 1);

  sched_state_t    state_q;
  logic [IcW-1:0]  init_cnt_q;
  logic [ColW-1:0] col_idx_q;
  err_code_t       err_q;
  logic [15:0]     frame_q;
  logic            auto_q;
  logic            wr_en_q;
  logic            wr_last_q;
  logic [ColW-1:0] wr_addr_q;

  logic accept;
  logic last_col;
  logic go_init;
  logic wd_clear;
  logic wd_enable;
  logic wd_expire;

  assign sink_req  = (state_q == StRun) && !sink_hold;
  assign accept    = sink_req && sink_rdy;
  assign last_col  = (col_idx_q == ColLast);
  assign wd_clear  = (state_q != StRun) || accept;
  assign wd_enable = (state_q == StRun) && !accept;

  // auto_q is the registered auto-restart enable; only DONE honours it.
  assign go_init = ((state_q == StIdle) && start) ||
                   ((state_q == StDone) && (start || auto_q)) ||
                   ((state_q == StErr) && start);

  stall_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_stall_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      init_cnt_q <= '0;
      col_idx_q  <= '0;
      err_q      <= ERR_NONE;
      frame_q    <= '0;
      auto_q     <= AUTO_DEF;
      wr_en_q    <= 1'b0;
      wr_last_q  <= 1'b0;
      wr_addr_q  <= '0;
    end else begin
      auto_q    <= auto_en;
      wr_en_q   <= accept;
      wr_last_q <= accept && sink_last;
      if (accept) begin
        wr_addr_q <= col_idx_q;
      end

      if (go_init) begin
        state_q    <= StInit;
        init_cnt_q <= InitLoad;
        err_q      <= ERR_NONE;
      end else begin
        unique case (state_q)
          StInit: begin
            col_idx_q <= '0;
            if (init_cnt_q == '0) begin
              state_q <= StRun;
            end else begin
              init_cnt_q <= init_cnt_q - 1'b1;
            end
          end
          StRun: begin
            if (accept) begin
              if (sink_last) begin
                if (last_col) begin
                  state_q <= StDone;
                  frame_q <= frame_q + 16'd1;
                end else begin
                  state_q <= StErr;
                  err_q   <= ERR_EARLY_LAST;
                end
              end else if (last_col) begin
                state_q <= StErr;
                err_q   <= ERR_NO_LAST;
              end else begin
                col_idx_q <= col_idx_q + 1'b1;
              end
            end else if (wd_expire) begin
              state_q <= StErr;
              err_q   <= ERR_TIMEOUT;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign init      = (state_q != StRun);
  assign busy      = (state_q == StInit) || (state_q == StRun);
  assign done      = (state_q == StDone);
  assign error     = (state_q == StErr);
  assign err_code  = err_q;
  assign frame_cnt = frame_q;
  assign wr_en     = wr_en_q;
  assign wr_last   = wr_last_q;
  assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_col_sched.sv
// Directed-plus-random bench for col_sched, checked every cycle against a
// time/count-based reference of the frame protocol.
module tb_col_sched;

  localparam int unsigned NCOL     = 256;
  localparam int unsigned INIT_CYC = 2;
  localparam int unsigned TIMEOUT  = 64;
  localparam bit          AUTO_DEF = 1'b0;

  localparam int O_IDLE = 0;
  localparam int O_DONE = 1;
  localparam int O_ERR  = 2;

  logic        clock = 1'b0;
  logic        reset_n, start, auto_en, sink_hold, sink_rdy, sink_last;
  logic        init, sink_req, wr_en, wr_last, busy, done, error;
  logic [7:0]  wr_addr;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;

  always #5 clock = ~clock;

  col_sched #(
    .NCOL    (NCOL),
    .INIT_CYC(INIT_CYC),
    .TIMEOUT (TIMEOUT),
    .AUTO_DEF(AUTO_DEF)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .auto_en  (auto_en),
    .sink_hold(sink_hold),
    .sink_rdy (sink_rdy),
    .sink_last(sink_last),
    .init     (init),
    .sink_req (sink_req),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_last  (wr_last),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_code (err_code),
    .frame_cnt(frame_cnt)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference: frame described by when RUN starts, columns taken, last accept time.
  bit          m_run;
  int          m_pend;
  int          m_outcome;
  int          m_cols;
  int          m_lastref;
  logic [15:0] m_frames;
  int          m_err;
  bit          m_wr_en;
  int          m_wr_addr;
  bit          m_wr_last;
  bit          m_auto;

  // Sink behaviour knobs.
  int rdy_mode;
  int last_at;
  int stuck_after;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_run     = 1'b0;
    m_pend    = -1;
    m_outcome = O_IDLE;
    m_cols    = 0;
    m_lastref = 0;
    m_frames  = '0;
    m_err     = 0;
    m_wr_en   = 1'b0;
    m_wr_addr = 0;
    m_wr_last = 1'b0;
    m_auto    = AUTO_DEF;
  endfunction

  function automatic void model_update(input bit acc);
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_wr_en   = acc;
    m_wr_last = acc && sink_last;
    if (m_run) begin
      if (acc) begin
        m_wr_addr = m_cols;
        m_lastref = cyc;
        if (sink_last || m_cols == NCOL - 1) begin
          m_run = 1'b0;
          if (sink_last && m_cols == NCOL - 1) begin
            m_outcome = O_DONE;
            m_frames++;
          end else begin
            m_outcome = O_ERR;
            m_err     = sink_last ? 1 : 2;
          end
        end
        m_cols++;
      end else if (cyc - m_lastref == TIMEOUT - 1) begin
        m_run     = 1'b0;
        m_outcome = O_ERR;
        m_err     = 3;
      end
    end else if (m_pend >= 0) begin
      if (cyc + 1 == m_pend) begin
        m_run     = 1'b1;
        m_pend    = -1;
        m_cols    = 0;
        m_lastref = cyc;
      end
    end else if (start || (m_outcome == O_DONE && m_auto)) begin
      m_pend = cyc + 1 + INIT_CYC;
      m_err  = 0;
    end
    m_auto = auto_en;
  endfunction

  task automatic step();
    bit exp_req, acc, m_busy;
    if (rdy_mode == 0) sink_rdy = (cyc % 2 == 0);
    else if (rdy_mode == 1) sink_rdy = ($urandom_range(0, 3) != 0);
    else sink_rdy = (m_cols <= stuck_after) && (cyc % 2 == 0);
    sink_last = (m_cols == last_at);
    #4;
    exp_req = m_run && !sink_hold;
    chk("sink_req", 32'(sink_req), 32'(exp_req));
    acc = exp_req && sink_rdy;
    model_update(acc);
    @(posedge clock);
    #1;
    cyc++;
    m_busy = m_run || (m_pend >= 0);
    chk("init", 32'(init), 32'(!m_run));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(!m_busy && m_outcome == O_DONE));
    chk("error", 32'(error), 32'(!m_busy && m_outcome == O_ERR));
    chk("err_code", 32'(err_code), 32'(m_err));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    chk("wr_en", 32'(wr_en), 32'(m_wr_en));
    chk("wr_last", 32'(wr_last), 32'(m_wr_last));
    if (m_wr_en || !reset_n) chk("wr_addr", 32'(wr_addr), m_wr_addr);
  endtask

  task automatic run_frame(input int limit);
    int n = 0;
    while ((m_run || m_pend >= 0) && n < limit) begin
      step();
      n++;
    end
    chk("frame_end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    auto_en     = 1'b0;
    sink_hold   = 1'b0;
    sink_rdy    = 1'b0;
    sink_last   = 1'b0;
    rdy_mode    = 0;
    last_at     = NCOL - 1;
    stuck_after = NCOL;
    model_reset();
    @(posedge clock);
    #1;

    // Reset values.
    step();
    reset_n = 1'b1;
    step();
    step();

    // Nominal frame, ready every other cycle.
    start = 1'b1; step(); start = 1'b0;
    run_frame(1200);
    repeat (5) step();

    // Back-pressure hold mid-frame.
    start = 1'b1; step(); start = 1'b0;
    repeat (100) step();
    sink_hold = 1'b1;
    repeat (50) step();
    sink_hold = 1'b0;
    run_frame(1500);

    // Early last on column 10; auto_en must not leave ERR.
    rdy_mode = 1;
    last_at  = 10;
    start = 1'b1; step(); start = 1'b0;
    run_frame(200);
    auto_en = 1'b1;
    repeat (5) step();
    auto_en = 1'b0;
    step();

    // Missing last on the final column.
    last_at = NCOL + 10;
    start = 1'b1; step(); start = 1'b0;
    run_frame(1500);

    // Stall timeout: ready dies after column 5.
    last_at     = NCOL - 1;
    rdy_mode    = 2;
    stuck_after = 5;
    start = 1'b1; step(); start = 1'b0;
    run_frame(300);
    repeat (10) step();

    // Auto-restart over three frames with stray starts during RUN.
    reset_n = 1'b0; step(); reset_n = 1'b1; step();
    rdy_mode = 1;
    auto_en  = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      start = (m_run && m_cols < 250) ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (m_frames == 16'd2 && m_run && m_cols >= 200) auto_en = 1'b0;
      step();
      if (m_frames == 16'd3 && !(m_run || m_pend >= 0)) break;
    end
    start = 1'b0;
    chk("auto_frames", 32'(frame_cnt), 32'd3);
    repeat (5) step();

    // Reset at column 100, then a clean frame from address 0.
    auto_en  = 1'b0;
    rdy_mode = 0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (m_run && m_cols == 100) break;
      step();
    end
    reset_n = 1'b0; step(); reset_n = 1'b1;
    repeat (10) step();
    start = 1'b1; step(); start = 1'b0;
    run_frame(1200);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/col_sched.md
# col_sched

Frame-level sequencer for the column pipeline (input_col → grey_pipe → later stages). It holds the pipeline in `init` between frames and releases it on a start request. It then drives the sink-side `data_req` of the final stage, counts accepted columns, and emits a registered write strobe per column for the result store. It detects end-of-frame, column-count mismatch and stall timeout, and replaces the ad hoc `init` generation at top level.

## Interface
- `NCOL`, 256: columns per frame; column index width is clog2(NCOL).
- `INIT_CYC`, 2: cycles `init` is held after start before release; must be ≥1.
- `TIMEOUT`, 4096: max cycles in RUN without an accepted column before error.
- `AUTO_DEF`, 0: reset value of the auto-restart enable.
- `clock`  in  1  sole clock, all logic posedge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  level; sampled in IDLE, DONE, ERR.
- `auto_en`  in  1  when 1, DONE restarts the next frame without `start`.
- `sink_hold`  in  1  result store back-pressure; suppresses `sink_req`.
- `sink_rdy`  in  1  final stage `data_rdy_out`.
- `sink_last`  in  1  final stage `last_col_out`.
- `init`  out  1  pipeline init, to all stages.
- `sink_req`  out  1  final stage `data_req_in`.
- `wr_en`  out  1  registered column write strobe.
- `wr_addr`  out  clog2(NCOL)  column index of the write.
- `wr_last`  out  1  qualifies `wr_en` for the final column.
- `busy`  out  1  state is INIT or RUN.
- `done`  out  1  state is DONE.
- `error`  out  1  state is ERR.
- `err_code`  out  2  0 none, 1 early last, 2 missing last, 3 timeout.
- `frame_cnt`  out  16  frames completed; wraps at 2^16.

## Operation
- States: IDLE, INIT, RUN, DONE, ERR. Outputs are Moore-decoded from the registered state, except `sink_req`.
- `init` = 1 in IDLE, INIT, DONE and ERR; 0 only in RUN.
- `sink_req` = (state==RUN) & ~`sink_hold`, combinational.
- Accept = `sink_req` & `sink_rdy`.
- IDLE: `start`=1 → INIT. The init counter loads `INIT_CYC`-1.
- INIT: the counter decrements; at 0 → RUN. Column index and watchdog clear.
- RUN, accept with `sink_last`=1:
  - col_idx==NCOL-1 → DONE and `frame_cnt`++.
  - Otherwise → ERR, code 1.
- RUN, accept with `sink_last`=0:
  - col_idx==NCOL-1 → ERR, code 2.
  - Otherwise col_idx++.
- Every accept, including the erroring one, clears the watchdog and produces a write: next cycle `wr_en`=1, `wr_addr`=col_idx at accept, `wr_last`=`sink_last`.
- RUN, no accept: the watchdog increments. Reaching TIMEOUT-1 → ERR, code 3.
- `sink_hold` does not pause the watchdog. A held consumer is a stall.
- DONE: (`auto_en` | `start`) → INIT. Otherwise DONE persists.
- ERR: `start` → INIT and clears `err_code`. `auto_en` is ignored.
- `start` in INIT or RUN is ignored.
- `err_code` holds its value until the next INIT entry or reset.

## Timing
- Reset (`reset_n`=0 at posedge) puts the block in IDLE.
  - `init`=1; `sink_req`, `wr_en`, `wr_last`, `busy`, `done`, `error` = 0.
  - `wr_addr`, `err_code`, `frame_cnt`, col_idx, watchdog = 0.
- Reset mid-RUN aborts the frame with no `wr_en`. Reset has priority over every transition.
- start → first `init`=0 cycle: exactly 1+`INIT_CYC` clock edges.
- Accept → `wr_en`: 1 cycle. Back-to-back accepts give back-to-back `wr_en`.
- Last accept at cycle t:
  - t+1: `done`=1, `wr_en`=1, `wr_last`=1, `frame_cnt` incremented, `init`=1.
- DONE with `auto_en`=1 → next RUN: 1+`INIT_CYC` cycles.
- `sink_hold` rising in the same cycle as `sink_rdy` means no accept.

## Structure
- Package `col_pkg`: `sched_state_t` enum, `err_code_t` enum (ERR_NONE, ERR_EARLY_LAST, ERR_NO_LAST, ERR_TIMEOUT), `NCOL_DEF` constant.
- Sub-module `stall_timer`: clear/enable/expire counter parameterised by `TIMEOUT`. The init counter is inline.

## Test plan
- Nominal frame: reset, `start` pulse, sink model asserts `sink_rdy` every 2 cycles, `sink_last` on column 255.
  - 256 `wr_en`, addresses 0..255 in order.
  - `wr_last` only with address 255.
  - `done`=1, `frame_cnt`=1, `init` high again.
- Back-pressure: `sink_hold`=1 for 50 cycles mid-frame, TIMEOUT=4096.
  - No accepts while held; the frame completes with 256 writes; no error.
- Early last: `sink_last`=1 on column 10.
  - `wr_en` with `wr_addr`=10, `wr_last`=1; `error`=1, `err_code`=1, `frame_cnt`=0.
  - A later `start` reaches RUN with `err_code`=0.
- Timeout: TIMEOUT=64, `sink_rdy` stuck 0 after column 5.
  - ERR with code 3 exactly 64 cycles after the last accept; `sink_req`=0 thereafter.
- Auto-restart: `auto_en`=1, three frames.
  - `frame_cnt`=3.
  - Gap from each DONE to the next `init`=0 is 1+`INIT_CYC` cycles.
  - `start` asserted during RUN has no effect.
- Reset mid-frame: `reset_n`=0 at column 100.
  - IDLE next cycle with all reset values; no further `wr_en`.
  - A new `start` restarts from `wr_addr`=0.
